// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct fields, ALU codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct to ALU control decode; purely combinational, valid_o low for unsupported funct.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctrl_o = ALU_AND;
    valid_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: valid_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory-wait timeout and sticky error; Moore outputs except pc_en/ir_write/err.
// Optional perf counters (cyc_cnt, instr_cnt) are built only with MIPS_MC_CTRL_PERF_EN defined.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       pc_en,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state,
  output logic       err
`ifdef MIPS_MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q;
  logic          quiet_q;
  logic          timeout;
  logic [2:0]    dec_ctrl;
  logic          dec_ok;

  mips_alu_dec u_alu_dec (
    .funct_i    (funct),
    .alu_ctrl_o (dec_ctrl),
    .valid_o    (dec_ok)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_en      = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_ctrl   = ALU_AND;
    timeout    = (wait_q == WW'(WAIT_MAX)) && !mem_ready;

    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        // The cycle right after reset keeps every strobe quiet before the first fetch.
        if (!quiet_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout) begin
            state_d = S_ERROR;
          end
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_ctrl;
        state_d   = dec_ok ? S_ALUWB : S_ERROR;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_ERROR;
    endcase

    // Counter restarts whenever a new state is entered; only the memory states can hold.
    if (state_d != state_q)          wait_d = '0;
    else if (mem_req && !mem_ready)  wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      err_q   <= 1'b0;
      quiet_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_q | (state_d == S_ERROR);
      quiet_q <= 1'b0;
    end
  end

  assign state = state_q;
  assign err   = err_q;

`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] cyc_q, instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_ERROR)                          cyc_q   <= cyc_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH)    instr_q <= instr_q + 32'd1;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`endif

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, the maximum number of cycles a memory request may wait for mem_ready.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port op, input, 6 bits: instruction opcode from the instruction register.
REQ-005 The block SHALL have port funct, input, 6 bits: R-type function field.
REQ-006 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-008 The block SHALL have ports mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a and pc_en, each an output of 1 bit: datapath strobes and mux selects.
REQ-009 The block SHALL have ports alu_src_b (2), pc_src (2) and alu_ctrl (3), all outputs: ALU B mux, PC mux and ALU operation.
REQ-010 The block SHALL have port state, output, 4 bits: current FSM state, for debug.
REQ-011 The block SHALL have port err, output, 1 bit: sticky illegal-opcode or memory-timeout flag.

Function
REQ-012 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ERROR=12.
REQ-013 FETCH SHALL assert mem_req with iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=010 and pc_src=00, and assert ir_write and pc_en only in the cycle mem_ready=1; it then moves to DECODE, otherwise it holds.
REQ-014 DECODE SHALL set alu_src_a=0, alu_src_b=11 and alu_ctrl=010, then branch on op: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other value -> ERROR.
REQ-015 MEMADR SHALL set alu_src_a=1, alu_src_b=10 and alu_ctrl=010, then go to MEMRD for lw or MEMWR for sw.
REQ-016 MEMRD SHALL assert mem_req with iord=1 and hold until mem_ready, then go to MEMWB.
REQ-017 MEMWR SHALL assert mem_req and mem_we with iord=1 and hold until mem_ready, then go to FETCH.
REQ-018 MEMWB SHALL assert reg_write with mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-019 EXEC SHALL set alu_src_a=1 and alu_src_b=00, and decode funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct SHALL go to ERROR; otherwise it goes to ALUWB.
REQ-020 ALUWB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-021 BRANCH SHALL set alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01 and pc_en=zero, then go to FETCH.
REQ-022 ADDIEX SHALL set alu_src_a=1, alu_src_b=10 and alu_ctrl=010, then go to ADDIWB; ADDIWB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-023 JUMP SHALL set pc_src=10 and pc_en=1, then go to FETCH.
REQ-024 Any strobe or select not stated for a state SHALL be 0; all outputs SHALL be Moore-decoded from state, except pc_en, ir_write and err.
REQ-025 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment on each cycle with mem_req=1 and mem_ready=0.
REQ-026 When the wait counter equals WAIT_MAX with mem_ready=0, the FSM SHALL go to ERROR; if mem_ready=1 arrives in that same cycle, the access SHALL complete normally.
REQ-027 ERROR SHALL hold all strobes at 0 and assert err; only reset SHALL leave ERROR.
REQ-028 Each instruction class SHALL take these cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each memory state adds one cycle per wait cycle.

Reset
REQ-029 reset=1 at a clock edge SHALL force FETCH, clear err and the wait counter, and drive all strobes to 0 in the next cycle, including when reset arrives mid-instruction or in ERROR.
REQ-030 reset SHALL take priority over mem_ready and every other input.

Configuration
REQ-031 With MIPS_MC_CTRL_PERF_EN defined, the block SHALL add 32-bit outputs cyc_cnt and instr_cnt, both cleared by reset.
REQ-032 cyc_cnt SHALL increment every cycle outside ERROR; instr_cnt SHALL increment on each transition into FETCH from a non-FETCH state; both wrap from 0xFFFFFFFF to 0.
REQ-033 Without MIPS_MC_CTRL_PERF_EN defined, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-034 State encodings, opcode and funct constants, and ALU control codes SHALL live in shared package mips_pkg.
REQ-035 The funct-to-alu_ctrl decode SHALL be a sub-module named mips_alu_dec.

Verification
REQ-036 Bench: lw (op=100011) with mem_ready tied to 1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in cycle 5.
REQ-037 Bench: R-type sub (funct=100010) -> alu_ctrl=110 in EXEC; reg_write=1 with reg_dst=1 in ALUWB; 4 cycles total.
REQ-038 Bench: beq with zero=1, then with zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first, pc_en=0 for the second.
REQ-039 Bench: FETCH with mem_ready held at 0 for 16 cycles (WAIT_MAX=15) -> ERROR and err=1; reset -> FETCH and err=0.
REQ-040 Bench: op=111111 -> ERROR after DECODE; a sw with mem_ready delayed 3 cycles -> MEMWR held 4 cycles with mem_we=1.
REQ-041 Bench: reset asserted in MEMRD -> next cycle state=0 with all strobes 0; with the macro defined, instr_cnt=0.
